// File: rtl/ahbl_arbiter_rr.sv
// N-to-1 AHB-Lite arbiter with per-port address-phase hold and lock support.
// AHBL_ARB_ROUND_ROBIN_EN selects round-robin grant; otherwise fixed priority.
module ahbl_arbiter_rr #(
  parameter int N_PORTS = 2,
  parameter int W_ADDR  = 32,
  parameter int W_DATA  = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_PORTS-1:0]          ahblm_hready,
  output logic [N_PORTS-1:0]          ahblm_hready_resp,
  output logic [N_PORTS-1:0]          ahblm_hresp,
  input  logic [N_PORTS*W_ADDR-1:0]   ahblm_haddr,
  input  logic [N_PORTS-1:0]          ahblm_hwrite,
  input  logic [N_PORTS*2-1:0]        ahblm_htrans,
  input  logic [N_PORTS*3-1:0]        ahblm_hsize,
  input  logic [N_PORTS*3-1:0]        ahblm_hburst,
  input  logic [N_PORTS*4-1:0]        ahblm_hprot,
  input  logic [N_PORTS-1:0]          ahblm_hmastlock,
  input  logic [N_PORTS*W_DATA-1:0]   ahblm_hwdata,
  output logic [N_PORTS*W_DATA-1:0]   ahblm_hrdata,
  output logic                        ahbls_hready,
  input  logic                        ahbls_hready_resp,
  input  logic                        ahbls_hresp,
  output logic [W_ADDR-1:0]           ahbls_haddr,
  output logic                        ahbls_hwrite,
  output logic [1:0]                  ahbls_htrans,
  output logic [2:0]                  ahbls_hsize,
  output logic [2:0]                  ahbls_hburst,
  output logic [3:0]                  ahbls_hprot,
  output logic                        ahbls_hmastlock,
  output logic [W_DATA-1:0]           ahbls_hwdata,
  input  logic [W_DATA-1:0]           ahbls_hrdata
);

  localparam int PW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

  typedef struct packed {
    logic [W_ADDR-1:0] addr;
    logic              write;
    logic [1:0]        trans;
    logic [2:0]        size;
    logic [2:0]        burst;
    logic [3:0]        prot;
    logic              lock;
  } aph_t;

  aph_t live [N_PORTS];
  aph_t hold [N_PORTS];
  aph_t cur  [N_PORTS];
  aph_t sel_aph;

  logic [N_PORTS-1:0] hold_valid;
  logic [N_PORTS-1:0] live_req;
  logic [N_PORTS-1:0] req;
  logic [N_PORTS-1:0] accept;
  logic [N_PORTS-1:0] cap;

  logic          dp_valid;
  logic [PW-1:0] dp_port;
  logic          locked;
  logic [PW-1:0] lock_port;
  logic [PW-1:0] win;
  logic [PW-1:0] sel;
  logic          found;
  logic          any_sel;

  // Live requests are masked in reset so the slave side reads IDLE.
  always_comb begin
    for (int i = 0; i < N_PORTS; i++) begin
      live[i].addr  = ahblm_haddr[i*W_ADDR +: W_ADDR];
      live[i].write = ahblm_hwrite[i];
      live[i].trans = ahblm_htrans[i*2 +: 2];
      live[i].size  = ahblm_hsize[i*3 +: 3];
      live[i].burst = ahblm_hburst[i*3 +: 3];
      live[i].prot  = ahblm_hprot[i*4 +: 4];
      live[i].lock  = ahblm_hmastlock[i];
      live_req[i]   = rst_n & ahblm_htrans[i*2+1] & ahblm_hready[i];
      req[i]        = hold_valid[i] | live_req[i];
      cur[i]        = hold_valid[i] ? hold[i] : live[i];
    end
  end

`ifdef AHBL_ARB_ROUND_ROBIN_EN
  logic [PW-1:0] ptr;
  logic [PW-1:0] ix;

  always_comb begin
    win   = '0;
    found = 1'b0;
    ix    = '0;
    for (int k = 1; k <= N_PORTS; k++) begin
      ix = PW'((int'(ptr) + k) % N_PORTS);
      if (!found && req[ix]) begin
        found = 1'b1;
        win   = ix;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= PW'(N_PORTS-1);
    end else if (ahbls_hready_resp && any_sel
                 && sel_aph.trans[1] && !locked) begin
      ptr <= sel;
    end
  end
`else
  always_comb begin
    win = '0;
    for (int i = N_PORTS-1; i >= 0; i--) begin
      if (req[i]) win = PW'(i);
    end
    found = |req;
  end
`endif

  assign sel     = locked ? lock_port : win;
  assign any_sel = locked | found;
  assign sel_aph = cur[sel];

  always_comb begin
    for (int i = 0; i < N_PORTS; i++) begin
      accept[i] = ahbls_hready_resp & any_sel & (sel == PW'(i));
      cap[i]    = live_req[i] & ~hold_valid[i] & ~accept[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_valid <= '0;
      for (int i = 0; i < N_PORTS; i++) hold[i] <= '0;
    end else begin
      for (int i = 0; i < N_PORTS; i++) begin
        if (hold_valid[i]) begin
          if (accept[i]) hold_valid[i] <= 1'b0;
        end else if (cap[i]) begin
          hold_valid[i] <= 1'b1;
          hold[i]       <= live[i];
        end
      end
    end
  end

  // Data-phase owner and lock owner both advance only on accepted cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dp_valid  <= 1'b0;
      dp_port   <= '0;
      locked    <= 1'b0;
      lock_port <= '0;
    end else if (ahbls_hready_resp) begin
      dp_valid <= any_sel & sel_aph.trans[1];
      dp_port  <= sel;
      if (any_sel) begin
        locked    <= sel_aph.lock;
        lock_port <= sel;
      end
    end
  end

  always_comb begin
    ahbls_haddr     = '0;
    ahbls_hwrite    = 1'b0;
    ahbls_htrans    = 2'b00;
    ahbls_hsize     = '0;
    ahbls_hburst    = '0;
    ahbls_hprot     = '0;
    ahbls_hmastlock = 1'b0;
    if (any_sel) begin
      ahbls_haddr     = sel_aph.addr;
      ahbls_hwrite    = sel_aph.write;
      ahbls_htrans    = sel_aph.trans;
      ahbls_hsize     = sel_aph.size;
      ahbls_hburst    = sel_aph.burst;
      ahbls_hprot     = sel_aph.prot;
      ahbls_hmastlock = sel_aph.lock;
    end
  end

  always_comb begin
    for (int i = 0; i < N_PORTS; i++) begin
      ahblm_hready_resp[i] = 1'b1;
      ahblm_hresp[i]       = 1'b0;
      if (hold_valid[i]) begin
        ahblm_hready_resp[i] = 1'b0;
      end else if (dp_valid && dp_port == PW'(i)) begin
        ahblm_hready_resp[i] = ahbls_hready_resp;
        ahblm_hresp[i]       = ahbls_hresp;
      end
    end
  end

  assign ahbls_hready = ahbls_hready_resp;
  assign ahbls_hwdata = ahblm_hwdata[int'(dp_port)*W_DATA +: W_DATA];
  assign ahblm_hrdata = {N_PORTS{ahbls_hrdata}};

endmodule

// File: tb/tb_ahbl_arbiter_rr.sv
// Directed bench for ahbl_arbiter_rr with a downstream-order scoreboard.
// Expectations follow AHBL_ARB_ROUND_ROBIN_EN when it is defined.
module tb_ahbl_arbiter_rr;
  localparam int N  = 2;
  localparam int WA = 32;
  localparam int WD = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]    ahblm_hready, ahblm_hready_resp, ahblm_hresp;
  logic [N*WA-1:0] ahblm_haddr;
  logic [N-1:0]    ahblm_hwrite, ahblm_hmastlock;
  logic [N*2-1:0]  ahblm_htrans;
  logic [N*3-1:0]  ahblm_hsize, ahblm_hburst;
  logic [N*4-1:0]  ahblm_hprot;
  logic [N*WD-1:0] ahblm_hwdata, ahblm_hrdata;
  logic            ahbls_hready, ahbls_hready_resp, ahbls_hresp;
  logic [WA-1:0]   ahbls_haddr;
  logic            ahbls_hwrite, ahbls_hmastlock;
  logic [1:0]      ahbls_htrans;
  logic [2:0]      ahbls_hsize, ahbls_hburst;
  logic [3:0]      ahbls_hprot;
  logic [WD-1:0]   ahbls_hwdata, ahbls_hrdata;

  logic [WA-1:0] m_addr  [N];
  logic [1:0]    m_trans [N];
  logic          m_write [N];
  logic          m_lock  [N];
  logic [WD-1:0] m_wdata [N];

  ahbl_arbiter_rr #(.N_PORTS(N), .W_ADDR(WA), .W_DATA(WD)) dut (
    .clk(clk), .rst_n(rst_n),
    .ahblm_hready(ahblm_hready),
    .ahblm_hready_resp(ahblm_hready_resp),
    .ahblm_hresp(ahblm_hresp),
    .ahblm_haddr(ahblm_haddr),
    .ahblm_hwrite(ahblm_hwrite),
    .ahblm_htrans(ahblm_htrans),
    .ahblm_hsize(ahblm_hsize),
    .ahblm_hburst(ahblm_hburst),
    .ahblm_hprot(ahblm_hprot),
    .ahblm_hmastlock(ahblm_hmastlock),
    .ahblm_hwdata(ahblm_hwdata),
    .ahblm_hrdata(ahblm_hrdata),
    .ahbls_hready(ahbls_hready),
    .ahbls_hready_resp(ahbls_hready_resp),
    .ahbls_hresp(ahbls_hresp),
    .ahbls_haddr(ahbls_haddr),
    .ahbls_hwrite(ahbls_hwrite),
    .ahbls_htrans(ahbls_htrans),
    .ahbls_hsize(ahbls_hsize),
    .ahbls_hburst(ahbls_hburst),
    .ahbls_hprot(ahbls_hprot),
    .ahbls_hmastlock(ahbls_hmastlock),
    .ahbls_hwdata(ahbls_hwdata),
    .ahbls_hrdata(ahbls_hrdata)
  );

  // Each master sees its own response as bus HREADY.
  assign ahblm_hready = ahblm_hready_resp;
  assign ahblm_hsize  = {N{3'b010}};
  assign ahblm_hburst = '0;
  assign ahblm_hprot  = {N{4'b0011}};

  always_comb begin
    ahblm_haddr     = '0;
    ahblm_hwrite    = '0;
    ahblm_htrans    = '0;
    ahblm_hmastlock = '0;
    ahblm_hwdata    = '0;
    for (int i = 0; i < N; i++) begin
      ahblm_haddr[i*WA +: WA]  = m_addr[i];
      ahblm_hwrite[i]          = m_write[i];
      ahblm_htrans[i*2 +: 2]   = m_trans[i];
      ahblm_hmastlock[i]       = m_lock[i];
      ahblm_hwdata[i*WD +: WD] = m_wdata[i];
    end
  end

  typedef struct {
    logic [WA-1:0] addr;
    logic          write;
    logic [WD-1:0] wdata;
  } exp_t;

  exp_t sbq[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] want);
    n_vec++;
    assert (obs === want) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  task automatic push(input logic [WA-1:0] a, input logic w,
                      input logic [WD-1:0] d);
    exp_t e;
    e.addr = a; e.write = w; e.wdata = d;
    sbq.push_back(e);
  endtask

  task automatic drv(input int p, input logic [1:0] tr,
                     input logic [WA-1:0] a, input logic w, input logic lk);
    m_trans[p] = tr; m_addr[p] = a; m_write[p] = w; m_lock[p] = lk;
  endtask

  task automatic idle(input int p);
    drv(p, 2'b00, '0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Downstream monitor: accepted address phases pop the scoreboard,
  // write data is checked when the following data phase completes.
  logic pend = 1'b0;
  exp_t pend_e;
  always @(negedge clk) begin
    if (!rst_n) begin
      pend = 1'b0;
    end else begin
      if (pend && ahbls_hready) begin
        if (pend_e.write) chk("sb_hwdata", ahbls_hwdata, pend_e.wdata);
        pend = 1'b0;
      end
      if (ahbls_htrans[1] && ahbls_hready) begin
        chk("sb_nonempty", sbq.size() != 0, 1);
        if (sbq.size() != 0) begin
          pend_e = sbq.pop_front();
          chk("sb_haddr", ahbls_haddr, pend_e.addr);
          chk("sb_hwrite", ahbls_hwrite, pend_e.write);
          pend = 1'b1;
        end
      end
    end
  end

  logic [WA-1:0] ex_b, ex_c, first_a, second_a;
  int loser, c_wait_port;

  initial begin
    for (int i = 0; i < N; i++) begin
      idle(i);
      m_wdata[i] = '0;
    end
    ahbls_hready_resp = 1'b1;
    ahbls_hresp = 1'b0;
    ahbls_hrdata = '0;

    // reset values, even with a live request present
    #2;
    drv(1, 2'b10, 32'h2000_0010, 1'b0, 1'b0);
    #2;
    chk("rst_hready_resp", ahblm_hready_resp, 2'b11);
    chk("rst_hresp", ahblm_hresp, 2'b00);
    chk("rst_htrans", ahbls_htrans, 2'b00);
    chk("rst_hmastlock", ahbls_hmastlock, 1'b0);
    idle(1);
    #10 rst_n = 1'b1;

    // single master pass-through
    tick();
    drv(1, 2'b10, 32'h2000_0010, 1'b0, 1'b0);
    push(32'h2000_0010, 1'b0, '0);
    #3;
    chk("t1_htrans", ahbls_htrans, 2'b10);
    chk("t1_haddr", ahbls_haddr, 32'h2000_0010);
    chk("t1_hsize", ahbls_hsize, 3'b010);
    chk("t1_hprot", ahbls_hprot, 4'b0011);
    chk("t1_hburst", ahbls_hburst, 3'b000);
    tick();
    idle(1);
    ahbls_hrdata = 32'hDEAD_BEEF;
    #3;
    chk("t1_rdy", ahblm_hready_resp[1], 1'b1);
    chk("t1_rdata", ahblm_hrdata[63:32], 32'hDEAD_BEEF);

    // collision, then port 0 re-requests while port 1 is held
    tick();
    drv(0, 2'b10, 32'h100, 1'b1, 1'b0); m_wdata[0] = 32'hA0;
    drv(1, 2'b10, 32'h200, 1'b1, 1'b0); m_wdata[1] = 32'hB0;
    push(32'h100, 1'b1, 32'hA0);
    #3;
    chk("t2_a_haddr", ahbls_haddr, 32'h100);
    tick();
    drv(0, 2'b10, 32'h104, 1'b0, 1'b0);
    idle(1);
`ifdef AHBL_ARB_ROUND_ROBIN_EN
    push(32'h200, 1'b1, 32'hB0);
    push(32'h104, 1'b0, '0);
    ex_b = 32'h200; ex_c = 32'h104; c_wait_port = 0;
`else
    push(32'h104, 1'b0, '0);
    ex_b = 32'h104; ex_c = 32'h200; c_wait_port = 1;
`endif
    #3;
    chk("t2_b_p1_wait", ahblm_hready_resp[1], 1'b0);
    chk("t2_b_haddr", ahbls_haddr, ex_b);
    tick();
    idle(0);
`ifndef AHBL_ARB_ROUND_ROBIN_EN
    push(32'h200, 1'b1, 32'hB0);
`endif
    #3;
    chk("t2_c_haddr", ahbls_haddr, ex_c);
    chk("t2_c_wait", ahblm_hready_resp[c_wait_port], 1'b0);
    tick();
    #3;
    chk("t2_d_rdy", ahblm_hready_resp, 2'b11);

    // repeated collisions separated by gaps
    for (int r = 0; r < 4; r++) begin
      tick();
      drv(0, 2'b10, 32'h1000 + 32'(r*16), 1'b0, 1'b0);
      drv(1, 2'b10, 32'h2000 + 32'(r*16), 1'b0, 1'b0);
`ifdef AHBL_ARB_ROUND_ROBIN_EN
      first_a = 32'h2000 + 32'(r*16); second_a = 32'h1000 + 32'(r*16);
      loser = 0;
`else
      first_a = 32'h1000 + 32'(r*16); second_a = 32'h2000 + 32'(r*16);
      loser = 1;
`endif
      push(first_a, 1'b0, '0);
      push(second_a, 1'b0, '0);
      #3;
      chk("rep_first", ahbls_haddr, first_a);
      tick();
      idle(0);
      idle(1);
      #3;
      chk("rep_second", ahbls_haddr, second_a);
      chk("rep_loser_wait", ahblm_hready_resp[loser], 1'b0);
      tick();
    end

    // locked sequence on port 0 while port 1 requests
    tick();
    drv(0, 2'b10, 32'h3000, 1'b0, 1'b1);
    push(32'h3000, 1'b0, '0);
    #3;
    chk("lk1_hmastlock", ahbls_hmastlock, 1'b1);
    tick();
    drv(0, 2'b11, 32'h3004, 1'b0, 1'b1);
    drv(1, 2'b10, 32'h4000, 1'b1, 1'b0); m_wdata[1] = 32'hC1;
    push(32'h3004, 1'b0, '0);
    #3;
    chk("lk2_haddr", ahbls_haddr, 32'h3004);
    tick();
    drv(0, 2'b11, 32'h3008, 1'b0, 1'b1);
    idle(1);
    push(32'h3008, 1'b0, '0);
    #3;
    chk("lk3_p1_wait", ahblm_hready_resp[1], 1'b0);
    chk("lk3_haddr", ahbls_haddr, 32'h3008);
    tick();
    idle(0);
    #3;
    chk("lk4_p1_wait", ahblm_hready_resp[1], 1'b0);
    chk("lk4_htrans", ahbls_htrans, 2'b00);
    tick();
    push(32'h4000, 1'b1, 32'hC1);
    #3;
    chk("lk5_haddr", ahbls_haddr, 32'h4000);
    chk("lk5_hmastlock", ahbls_hmastlock, 1'b0);
    tick();
    #3;
    chk("lk6_p1_rdy", ahblm_hready_resp[1], 1'b1);

    // two-cycle slave error on port 0 while port 1 is held
    tick();
    drv(0, 2'b10, 32'h5000, 1'b1, 1'b0); m_wdata[0] = 32'hE0;
    drv(1, 2'b10, 32'h6000, 1'b1, 1'b0); m_wdata[1] = 32'hF0;
    push(32'h5000, 1'b1, 32'hE0);
    #3;
    chk("er1_haddr", ahbls_haddr, 32'h5000);
    tick();
    idle(0);
    idle(1);
    ahbls_hready_resp = 1'b0;
    ahbls_hresp = 1'b1;
    #3;
    chk("er2_rdy", ahblm_hready_resp, 2'b00);
    chk("er2_resp", ahblm_hresp, 2'b01);
    chk("er2_s_hready", ahbls_hready, 1'b0);
    tick();
    ahbls_hready_resp = 1'b1;
    push(32'h6000, 1'b1, 32'hF0);
    #3;
    chk("er3_rdy", ahblm_hready_resp, 2'b01);
    chk("er3_resp", ahblm_hresp, 2'b01);
    chk("er3_haddr", ahbls_haddr, 32'h6000);
    tick();
    ahbls_hresp = 1'b0;
    #3;
    chk("er4_rdy", ahblm_hready_resp, 2'b11);
    chk("er4_resp", ahblm_hresp, 2'b00);

    // reset while port 1 is held and a data phase is open
    tick();
    drv(0, 2'b10, 32'h7000, 1'b0, 1'b0);
    drv(1, 2'b10, 32'h8000, 1'b1, 1'b0);
    push(32'h7000, 1'b0, '0);
    tick();
    idle(0);
    idle(1);
    ahbls_hready_resp = 1'b0;
    #3;
    chk("rs_p1_wait", ahblm_hready_resp[1], 1'b0);
    chk("rs_held_htrans", ahbls_htrans, 2'b10);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rs_async_rdy", ahblm_hready_resp, 2'b11);
    chk("rs_async_resp", ahblm_hresp, 2'b00);
    chk("rs_async_htrans", ahbls_htrans, 2'b00);
    ahbls_hready_resp = 1'b1;
    #10 rst_n = 1'b1;
    tick();
    drv(1, 2'b10, 32'h9000, 1'b0, 1'b0);
    push(32'h9000, 1'b0, '0);
    #3;
    chk("rs_post_htrans", ahbls_htrans, 2'b10);
    chk("rs_post_haddr", ahbls_haddr, 32'h9000);
    tick();
    idle(1);
    #3;
    chk("rs_post_rdy", ahblm_hready_resp[1], 1'b1);
    tick();
    tick();
    chk("sb_drained", sbq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
